mic_level_compare: RTL and testbench



---
 rtl/mic_level_compare.sv | 155 +++++++++++++++
 tb/tb_mic_level_compare.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mic_level_compare.sv
// Pairs left/right mic samples, accumulates |amplitude| per channel over a window
// of 2^LOG2_WIN pairs, then publishes both energies and a left/centre/right decision.
module mic_level_compare #(
  parameter int LOG2_WIN = 10,
  parameter int DB_SHIFT = 3
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [17:0]             data,
  input  logic                    d_rdy_l,
  input  logic                    d_rdy_r,
  output logic [17+LOG2_WIN-1:0]  energy_l,
  output logic [17+LOG2_WIN-1:0]  energy_r,
  output logic [1:0]              dir,
  output logic                    result_valid,
  output logic [7:0]              drop_count
);

  localparam int AW = 17 + LOG2_WIN;
  localparam int XW = AW + 2;

  typedef enum logic {
    WAIT_L = 1'b0,
    HAVE_L = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [16:0]           held_l_q, held_l_d;
  logic [AW-1:0]         acc_l_q, acc_l_d, acc_r_q, acc_r_d;
  logic [LOG2_WIN-1:0]   pair_cnt_q, pair_cnt_d;
  logic [AW-1:0]         snap_l_q, snap_l_d, snap_r_q, snap_r_d;
  logic                  snap_vld_q, snap_vld_d;
  logic [AW-1:0]         energy_l_q, energy_l_d, energy_r_q, energy_r_d;
  logic [1:0]            dir_q, dir_d;
  logic                  result_valid_q, result_valid_d;
  logic [7:0]            drop_q, drop_d;

  logic [17:0]           neg;
  logic [16:0]           mag;
  logic [AW-1:0]         sum_l, sum_r;
  logic                  drop_inc;
  logic [XW-1:0]         ext_l, ext_r, dead;

  always_comb begin
    // Only -131072 leaves bit 17 set after negation; clamp it to the largest magnitude.
    neg   = ~data + 18'd1;
    mag   = data[17] ? (neg[17] ? 17'h1FFFF : neg[16:0]) : data[16:0];
    sum_l = acc_l_q + {{LOG2_WIN{1'b0}}, held_l_q};
    sum_r = acc_r_q + {{LOG2_WIN{1'b0}}, mag};

    state_d    = state_q;
    held_l_d   = held_l_q;
    acc_l_d    = acc_l_q;
    acc_r_d    = acc_r_q;
    pair_cnt_d = pair_cnt_q;
    snap_l_d   = snap_l_q;
    snap_r_d   = snap_r_q;
    snap_vld_d = 1'b0;
    drop_inc   = 1'b0;

    case (state_q)
      WAIT_L: begin
        if (d_rdy_l) begin
          held_l_d = mag;
          state_d  = HAVE_L;
          drop_inc = d_rdy_r;
        end else if (d_rdy_r) begin
          drop_inc = 1'b1;
        end
      end
      HAVE_L: begin
        if (d_rdy_l) begin
          held_l_d = mag;
          drop_inc = 1'b1;
        end else if (d_rdy_r) begin
          pair_cnt_d = pair_cnt_q + LOG2_WIN'(1);
          state_d    = WAIT_L;
          if (pair_cnt_q == '1) begin
            snap_l_d   = sum_l;
            snap_r_d   = sum_r;
            snap_vld_d = 1'b1;
            acc_l_d    = '0;
            acc_r_d    = '0;
          end else begin
            acc_l_d = sum_l;
            acc_r_d = sum_r;
          end
        end
      end
      default: state_d = WAIT_L;
    endcase

    drop_d = (drop_inc && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
  end

  always_comb begin
    // Two spare bits keep snap + dead from wrapping even with DB_SHIFT = 0.
    ext_l = XW'(snap_l_q);
    ext_r = XW'(snap_r_q);
    dead  = (ext_l + ext_r) >> DB_SHIFT;

    energy_l_d     = energy_l_q;
    energy_r_d     = energy_r_q;
    dir_d          = dir_q;
    result_valid_d = 1'b0;

    if (snap_vld_q) begin
      energy_l_d     = snap_l_q;
      energy_r_d     = snap_r_q;
      result_valid_d = 1'b1;
      if (ext_l > ext_r + dead)      dir_d = 2'b01;
      else if (ext_r > ext_l + dead) dir_d = 2'b10;
      else                           dir_d = 2'b00;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= WAIT_L;
      held_l_q       <= '0;
      acc_l_q        <= '0;
      acc_r_q        <= '0;
      pair_cnt_q     <= '0;
      snap_l_q       <= '0;
      snap_r_q       <= '0;
      snap_vld_q     <= 1'b0;
      energy_l_q     <= '0;
      energy_r_q     <= '0;
      dir_q          <= 2'b00;
      result_valid_q <= 1'b0;
      drop_q         <= '0;
    end else begin
      state_q        <= state_d;
      held_l_q       <= held_l_d;
      acc_l_q        <= acc_l_d;
      acc_r_q        <= acc_r_d;
      pair_cnt_q     <= pair_cnt_d;
      snap_l_q       <= snap_l_d;
      snap_r_q       <= snap_r_d;
      snap_vld_q     <= snap_vld_d;
      energy_l_q     <= energy_l_d;
      energy_r_q     <= energy_r_d;
      dir_q          <= dir_d;
      result_valid_q <= result_valid_d;
      drop_q         <= drop_d;
    end
  end

  assign energy_l     = energy_l_q;
  assign energy_r     = energy_r_q;
  assign dir          = dir_q;
  assign result_valid = result_valid_q;
  assign drop_count   = drop_q;

endmodule

// File: tb/tb_mic_level_compare.sv
// Scoreboard bench for mic_level_compare: stimulus updates a pairing/window model and
// queues expected results; a negedge monitor pops and compares when result_valid fires.
module tb_mic_level_compare;

  localparam int LW  = 2;
  localparam int DBS = 3;
  localparam int EW  = 17 + LW;
  localparam int WIN = 1 << LW;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [17:0]   data = '0;
  logic          d_rdy_l = 1'b0;
  logic          d_rdy_r = 1'b0;
  logic [EW-1:0] energy_l, energy_r;
  logic [1:0]    dir;
  logic          result_valid;
  logic [7:0]    drop_count;

  mic_level_compare #(.LOG2_WIN(LW), .DB_SHIFT(DBS)) dut (
    .clock        (clock),
    .reset        (reset),
    .data         (data),
    .d_rdy_l      (d_rdy_l),
    .d_rdy_r      (d_rdy_r),
    .energy_l     (energy_l),
    .energy_r     (energy_r),
    .dir          (dir),
    .result_valid (result_valid),
    .drop_count   (drop_count)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    longint el;
    longint er;
    int     dir;
    int     cyc;
  } exp_t;

  exp_t   sb_q[$];
  int     checks = 0;
  int     errors = 0;
  bit     mon_en = 1'b0;

  // Reference model state: whether a left is waiting, its magnitude, window sums and pair count.
  bit     m_have = 1'b0;
  longint m_held = 0;
  longint m_sum_l = 0;
  longint m_sum_r = 0;
  int     m_pairs = 0;
  int     m_drop = 0;
  longint hold_l = 0;
  longint hold_r = 0;
  int     hold_dir = 0;

  task automatic check_output(input string name, input longint actual, input longint expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  function automatic longint magnitude(input logic [17:0] v);
    logic signed [17:0] s;
    longint x;
    s = v;
    x = s;
    if (x < 0) x = -x;
    if (x > 131071) x = 131071;
    return x;
  endfunction

  function automatic int decide(input longint l, input longint r);
    longint dead;
    dead = (l + r) >> DBS;
    if (l > r + dead) return 1;
    if (r > l + dead) return 2;
    return 0;
  endfunction

  task automatic model_update(input bit l, input bit r, input logic [17:0] v);
    exp_t e;
    if (l) begin
      if (m_have || r) m_drop = (m_drop < 255) ? m_drop + 1 : 255;
      m_held = magnitude(v);
      m_have = 1'b1;
    end else if (r) begin
      if (!m_have) begin
        m_drop = (m_drop < 255) ? m_drop + 1 : 255;
      end else begin
        m_sum_l += m_held;
        m_sum_r += magnitude(v);
        m_have = 1'b0;
        m_pairs++;
        if (m_pairs == WIN) begin
          e.el  = m_sum_l;
          e.er  = m_sum_r;
          e.dir = decide(m_sum_l, m_sum_r);
          e.cyc = cyc + 1;
          sb_q.push_back(e);
          m_sum_l = 0;
          m_sum_r = 0;
          m_pairs = 0;
        end
      end
    end
  endtask

  task automatic apply_stimulus(input bit l, input bit r, input logic [17:0] v);
    @(negedge clock);
    d_rdy_l = l;
    d_rdy_r = r;
    data    = v;
    @(posedge clock);
    #1;
    model_update(l, r, v);
    d_rdy_l = 1'b0;
    d_rdy_r = 1'b0;
    data    = 18'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) apply_stimulus(1'b0, 1'b0, 18'($urandom));
  endtask

  task automatic pair(input logic [17:0] l, input logic [17:0] r);
    apply_stimulus(1'b1, 1'b0, l);
    apply_stimulus(1'b0, 1'b1, r);
  endtask

  task automatic apply_reset(input int n);
    @(negedge clock);
    reset = 1'b1;
    repeat (n) @(posedge clock);
    #1;
    sb_q.delete();
    m_have = 1'b0; m_held = 0; m_sum_l = 0; m_sum_r = 0; m_pairs = 0; m_drop = 0;
    hold_l = 0; hold_r = 0; hold_dir = 0;
    reset = 1'b0;
  endtask

  function automatic logic [17:0] rand_sample();
    int k;
    k = $urandom_range(0, 9);
    if (k == 0) return 18'h20000;
    if (k == 1) return 18'h1FFFF;
    if (k == 2) return 18'h0;
    return 18'($urandom);
  endfunction

  // Monitor: compares held outputs every cycle and pops the scoreboard on each result pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (mon_en) begin
        check_output("drop_count", longint'(drop_count), longint'(m_drop));
        if (result_valid) begin
          if (sb_q.size() == 0) begin
            check_output("unexpected_result_valid", 1, 0);
          end else begin
            e = sb_q.pop_front();
            check_output("result_cycle", longint'(cyc), longint'(e.cyc));
            check_output("energy_l", longint'(energy_l), e.el);
            check_output("energy_r", longint'(energy_r), e.er);
            check_output("dir", longint'(dir), longint'(e.dir));
            hold_l = e.el; hold_r = e.er; hold_dir = e.dir;
          end
        end else begin
          if (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
            e = sb_q.pop_front();
            check_output("missing_result_valid_due_cycle", longint'(cyc), longint'(e.cyc));
          end
          check_output("hold_energy_l", longint'(energy_l), hold_l);
          check_output("hold_energy_r", longint'(energy_r), hold_r);
          check_output("hold_dir", longint'(dir), longint'(hold_dir));
        end
      end
    end
  end

  initial begin
    apply_reset(2);
    mon_en = 1'b1;
    idle(2);

    // Equal energies, centre decision.
    repeat (4) pair(18'd1000, -18'sd1000);
    idle(4);
    check_output("s1_energy_l_const", longint'(energy_l), 4000);
    check_output("s1_dir_const", longint'(dir), 0);

    // Left-dominant window, then a window inside the deadband.
    repeat (4) pair(18'd2000, 18'd1000);
    idle(3);
    check_output("s2_dir_left_const", longint'(dir), 1);
    repeat (4) pair(18'd1000, 18'd1100);
    idle(3);

    // Most-negative sample saturates.
    repeat (4) pair(18'h20000, 18'd0);
    idle(3);
    check_output("s3_energy_l_const", longint'(energy_l), 524284);

    // Orphan right, overwritten left, then complete the window.
    apply_stimulus(1'b0, 1'b1, 18'd3);
    apply_stimulus(1'b1, 1'b0, 18'd5);
    apply_stimulus(1'b1, 1'b0, 18'd7);
    apply_stimulus(1'b0, 1'b1, 18'd9);
    repeat (3) pair(18'd0, 18'd0);
    idle(3);
    check_output("s4_energy_r_const", longint'(energy_r), 9);

    // Reset mid-window discards the partial sums.
    pair(18'd50, 18'd60);
    pair(18'd70, 18'd80);
    apply_reset(1);
    repeat (4) pair(18'd10, 18'd10);
    idle(3);
    check_output("s5_energy_l_const", longint'(energy_l), 40);

    // Reset in the cycle after the window end suppresses the pending result.
    repeat (4) pair(18'd500, 18'd100);
    apply_reset(1);
    idle(4);

    // Back-to-back strobes for three windows.
    repeat (3 * WIN) pair(rand_sample(), rand_sample());
    idle(3);

    // Random mix including simultaneous strobes and gaps.
    for (int i = 0; i < 400; i++) begin
      int k;
      k = $urandom_range(0, 9);
      if (k < 4)       apply_stimulus(1'b1, 1'b0, rand_sample());
      else if (k < 8)  apply_stimulus(1'b0, 1'b1, rand_sample());
      else if (k == 8) apply_stimulus(1'b1, 1'b1, rand_sample());
      else             idle(1);
      if (i == 200) apply_reset(1);
    end
    idle(3);

    // Drop counter saturation.
    repeat (270) apply_stimulus(1'b0, 1'b1, rand_sample());
    idle(2);
    check_output("drop_saturated_const", longint'(drop_count), 255);
    idle(4);

    check_output("scoreboard_drained", longint'(sb_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
